// File: rtl/fv_enc_pkg.sv
// Shared definitions for the polynomial-multiplier scheduler: FSM state
// encoding, requester count and the default watchdog limit.
package fv_enc_pkg;

  localparam int NREQ        = 2;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. With both requests pending the
// requester that was not granted last wins; the pointer lives in the parent.
module rr_arb2
  import fv_enc_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic            idx
);

  // Pick the winner from the request bits and the last-grant pointer
  always_comb begin
    idx = 1'b0;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req[1]) begin
      idx = 1'b1;
    end
  end

endmodule

// File: rtl/fv_mul_scheduler.sv
// Schedules jobs from two requesters onto one shared polynomial multiplier.
// Optional feature: define FV_MUL_WATCHDOG_EN to abort a job whose multiplier
// never answers (rsp_err=1 after TIMEOUT cycles in WAIT).
// All outputs are registered and derived from the next state, so each output
// appears in the same cycle as the state it belongs to.
module fv_mul_scheduler
  import fv_enc_pkg::*;
#(
  parameter int N       = 16,
  parameter int QW      = 5,
  parameter int UW      = 1,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_err,
  output logic            mul_start,
  output logic            mul_sel,
  input  logic            mul_done,
  output logic            busy
);

  // A degenerate configuration never accepts work.
  localparam bit CFG_OK = (N > 0) && (QW > 0) && (UW > 0) && (TIMEOUT > 1);

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic            arb_idx;
  logic [NREQ-1:0] ready_d, rsp_d;
  logic            start_d;

`ifdef FV_MUL_WATCHDOG_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
`endif

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (last_q),
    .idx  (arb_idx)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    ready_d = '0;
    rsp_d   = '0;
    start_d = 1'b0;
`ifdef FV_MUL_WATCHDOG_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (CFG_OK && (|req_valid)) begin
          state_d = S_GRANT;
          owner_d = arb_idx;
          last_d  = arb_idx;
          ready_d = arb_idx ? 2'b10 : 2'b01;
        end
      end
      S_GRANT: begin
        state_d = S_START;
        start_d = 1'b1;
      end
      S_START: begin
        // mul_done here coincides with mul_start and is deliberately ignored
        state_d = S_WAIT;
`ifdef FV_MUL_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          state_d = S_DONE;
          rsp_d   = owner_q ? 2'b10 : 2'b01;
`ifdef FV_MUL_WATCHDOG_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          rsp_d   = owner_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      mul_sel   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_d;
      mul_start <= start_d;
      mul_sel   <= (state_d == S_IDLE) ? 1'b0 : owner_d;
      busy      <= (state_d != S_IDLE);
    end
  end

`ifdef FV_MUL_WATCHDOG_EN
  // Watchdog counter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rsp_err <= err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/fv_mul_scheduler.md
FV_MUL_SCHEDULER -- requirements
Module: fv_mul_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 16, polynomial length; QW, default 5, coefficient width; UW, default 1, secret-polynomial coefficient width; TIMEOUT, default 64, watchdog limit in cycles.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  2  per-requester job request; held high until accepted.
REQ-006 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-007 rsp_valid  output  2  one-cycle completion pulse to the job owner.
REQ-008 rsp_err  output  1  qualifies rsp_valid; 1 = job aborted by the watchdog.
REQ-009 mul_start  output  1  one-cycle start pulse to the shared polynomial multiplier.
REQ-010 mul_sel  output  1  operand-mux select (owner index); stable from GRANT through DONE.
REQ-011 mul_done  input  1  one-cycle completion pulse from the multiplier.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, GRANT, START, WAIT and DONE.
REQ-014 IDLE SHALL go to GRANT when any req_valid bit is high; otherwise it SHALL stay in IDLE.
REQ-015 On entry to GRANT, the round-robin arbiter SHALL pick the owner; with both requests pending, the owner SHALL be the requester not granted last.
REQ-016 GRANT SHALL last one cycle: req_ready[owner]=1, mul_sel=owner latched, last-grant pointer updated; next state START.
REQ-017 START SHALL last one cycle: mul_start=1; next state WAIT.
REQ-018 WAIT SHALL hold until mul_done=1, then go to DONE.
REQ-019 DONE SHALL last one cycle: rsp_valid[owner]=1, rsp_err=0; next state IDLE.
REQ-020 Latency: with req_valid high in IDLE at cycle 0, req_ready SHALL be high at cycle 1 and mul_start at cycle 2; mul_done at cycle k SHALL give rsp_valid at cycle k+1.
REQ-021 mul_done outside WAIT SHALL be ignored, including mul_done coincident with mul_start.
REQ-022 A requester dropping req_valid before its accept SHALL lose its request with no other effect.
REQ-023 A new request from the current owner during a job SHALL wait in IDLE arbitration; the other requester SHALL win if it is pending.
REQ-024 At most one bit of req_ready and at most one bit of rsp_valid SHALL be high in any cycle.
REQ-025 Outputs SHALL be registered; all outputs SHALL be 0 in IDLE.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE and the last-grant pointer SHALL reset to 1, so requester 0 wins first.
REQ-027 On rst, all outputs SHALL be 0 and the watchdog counter SHALL clear.
REQ-028 Reset in any state SHALL abort the job silently, with no rsp_valid; mul_start SHALL be 0 in the cycle after reset.

Configuration
REQ-029 With FV_MUL_WATCHDOG_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 With FV_MUL_WATCHDOG_EN defined, the counter reaching TIMEOUT-1 without mul_done SHALL move the FSM to DONE with rsp_err=1.
REQ-031 With FV_MUL_WATCHDOG_EN defined, mul_done in the same cycle as the timeout SHALL win (rsp_err=0).
REQ-032 Without FV_MUL_WATCHDOG_EN, the watchdog counter SHALL not exist, WAIT SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Structure
REQ-033 The shared package fv_enc_pkg SHALL hold the FSM state encoding, the requester count (2) and the default TIMEOUT.
REQ-034 The arbitration SHALL be one sub-module, rr_arb2: a combinational two-way round-robin pick from the request bits and the last-grant pointer, with the pointer registered in the parent.

Verification
REQ-035 Single request: req_valid=01 held, mul_done 16 cycles after mul_start -> req_ready=01 at cycle 1, mul_start at cycle 2, rsp_valid=01 one cycle after mul_done, mul_sel=0 throughout.
REQ-036 Contention: req_valid=11 from reset, both held -> grant order 0,1,0,1 across four jobs, never two consecutive grants to the same requester.
REQ-037 Spurious done: mul_done pulsed in IDLE and in the START cycle -> no state change, no rsp_valid.
REQ-038 Reset mid-WAIT: rst asserted 5 cycles into WAIT -> busy=0 next cycle, no rsp_valid; the next job with req_valid=11 is granted to requester 0.
REQ-039 Watchdog (FV_MUL_WATCHDOG_EN, TIMEOUT=64): mul_done never asserted -> rsp_valid[owner]=1 with rsp_err=1 64 cycles after entering WAIT.
REQ-040 Watchdog boundary: mul_done in the timeout cycle -> rsp_err=0.
